// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: fixed-priority next-PC selection (exc > branch > jump > RAS return > sequential > hold).
// Optional return-address stack enabled by defining PC_RAS_EN; PC and pc_valid are registered, npc is combinational.
module pc_sequencer #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'('h180),
    parameter int                RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             exc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] PC,
    output logic             pc_valid,
    output logic [WIDTH-1:0] npc,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t           state;
    logic             advance;
    logic             redirect;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] pc_seq;

    assign advance    = (state == RUN) && fetch_ready && !stall;
    assign redirect   = exc || branch_taken || jump;
    assign pc_seq     = PC + WIDTH'(4);
    assign misaligned = (PC[1:0] != 2'b00);

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    top_ptr;
    logic             ras_push;

    assign top_ptr   = wr_ptr - PW'(1);
    assign ras_top   = ras_mem[top_ptr];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == (PW+1)'(RAS_DEPTH));
    assign ras_pop   = ret && advance && !redirect && !ras_empty;
    assign ras_push  = call && advance && !redirect;

    // Circular buffer: a push while full lands on the oldest slot, so count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (ras_push && ras_pop) begin
            ras_mem[top_ptr] <= pc_seq;
        end else if (ras_push) begin
            ras_mem[wr_ptr] <= pc_seq;
            wr_ptr          <= wr_ptr + PW'(1);
            if (!ras_full) count <= count + (PW+1)'(1);
        end else if (ras_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - (PW+1)'(1);
        end
    end
`else
    logic [9:0] unused_ras;

    assign unused_ras = {8'(RAS_DEPTH), call, ret};
    assign ras_pop    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    always_comb begin
        npc = PC;
        if (exc)                npc = EXC_VECTOR;
        else if (branch_taken)  npc = branch_target;
        else if (jump)          npc = jump_target;
        else if (ras_pop)       npc = ras_top;
        else if (advance)       npc = pc_seq;
    end

    // Redirects load PC in every state; only exc in RUN perturbs the state sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            PC       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            PC <= npc;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (exc) begin
                        state    <= FLUSH;
                        pc_valid <= 1'b0;
                    end else begin
                        pc_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences, and random traffic against a queue-based model.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] EXC   = 32'h180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, fetch_ready, exc, branch_taken, jump, call, ret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] PC, npc;
    logic        pc_valid, misaligned, ras_empty, ras_full;

    pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready), .exc(exc),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .call(call), .ret(ret), .PC(PC), .pc_valid(pc_valid),
        .npc(npc), .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch address, whether the fetch stage is in its running phase, return stack as a queue.
    logic [31:0] m_pc;
    bit          m_run;
    logic [31:0] ras_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_run = 1'b0;
        ras_q.delete();
    endtask

    task automatic set_in(input logic s, input logic fr, input logic e, input logic b, input logic [31:0] bt,
                          input logic j, input logic [31:0] jt, input logic c, input logic r);
        stall = s; fetch_ready = fr; exc = e; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; call = c; ret = r;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        bit          adv, redir, pop_ok;
        logic [31:0] n_pc;
        adv    = m_run && fetch_ready && !stall;
        redir  = exc || branch_taken || jump;
        pop_ok = RAS_ON && ret && adv && !redir && (ras_q.size() > 0);
        if (exc)               n_pc = EXC;
        else if (branch_taken) n_pc = branch_target;
        else if (jump)         n_pc = jump_target;
        else if (pop_ok)       n_pc = ras_q[$];
        else if (adv)          n_pc = m_pc + 32'd4;
        else                   n_pc = m_pc;
        #1;
        chk("npc", npc, n_pc);
        chk("misaligned", {31'b0, misaligned}, {31'b0, m_pc[1:0] != 2'b00});
        @(posedge clk);
        if (RAS_ON && adv && !redir) begin
            if (pop_ok) void'(ras_q.pop_back());
            if (call) begin
                ras_q.push_back(m_pc + 32'd4);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
        end
        m_run = m_run ? !exc : 1'b1;
        m_pc  = n_pc;
        #1;
        chk("pc", PC, m_pc);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_run});
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, ras_q.size() == 0});
        chk("ras_full", {31'b0, ras_full}, {31'b0, RAS_ON && ras_q.size() == DEPTH});
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        s, fr, e, b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] exp_pc;
        logic        exp_v, exp_m;
    } vec_t;

    vec_t vt [22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ret_exp [5];
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,         1'b0 | 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h4,         1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h8,         1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'hC,         1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h10,        1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h10,        1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 32'h0,         32'h40,        1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h40,        1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h44,        1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300,       32'h180,       1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h180,       1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h184,       1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1000,      32'h1000,      1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h1000,      1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0};
        vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,         1'b1, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h102,       32'h102,       1'b1, 1'b1};
        vt[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h106,       1'b1, 1'b1};
        vt[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200,       32'h200,       1'b1, 1'b0};
        vt[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h180,       1'b0, 1'b0};
        vt[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h180,       1'b1, 1'b0};
        vt[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h184,       1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_valid", {31'b0, pc_valid}, 32'h0);
        chk("reset_ras_empty", {31'b0, ras_empty}, 32'h1);
        chk("reset_ras_full", {31'b0, ras_full}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            set_in(vt[i].s, vt[i].fr, vt[i].e, vt[i].b, vt[i].bt, vt[i].j, vt[i].jt, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_pc", i), PC, vt[i].exp_pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, pc_valid}, {31'b0, vt[i].exp_v});
            chk($sformatf("vec%0d_mis", i), {31'b0, misaligned}, {31'b0, vt[i].exp_m});
        end

        // Calls at 0x00..0x40 on 16-byte boundaries, then five returns
        set_in(0, 1, 0, 0, 0, 1, 32'h0, 0, 0);
        step();
        for (int a = 0; a <= 32'h40; a += 4) begin
            set_in(0, 1, 0, 0, 0, 0, 0, (a % 16) == 0, 0);
            step();
        end
        chk("ras_after_calls_full", {31'b0, ras_full}, {31'b0, RAS_ON});
        if (RAS_ON) ret_exp = '{32'h44, 32'h34, 32'h24, 32'h14, 32'h18};
        else        ret_exp = '{32'h48, 32'h4C, 32'h50, 32'h54, 32'h58};
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 1);
            step();
            chk($sformatf("ret%0d_pc", k), PC, ret_exp[k]);
        end
        chk("ras_after_rets_empty", {31'b0, ras_empty}, 32'h1);

        // Asynchronous reset in the middle of a stall
        set_in(0, 1, 0, 0, 0, 1, 32'h80, 0, 0);
        step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("stall_hold_pc", PC, 32'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pc", PC, 32'h0);
        chk("async_reset_valid", {31'b0, pc_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] t1, t2;
            t1 = $urandom();
            t2 = $urandom();
            if ($urandom_range(0, 7) != 0) begin
                t1[1:0] = 2'b00;
                t2[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) t1 = 32'hFFFF_FFF8;
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                   $urandom_range(0, 15) == 0, t1, $urandom_range(0, 15) == 0, t2,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
